// File: rtl/msk_pkg.sv
// rtl/msk_pkg.sv - shared types, constants and helpers for the MSK bit deframer
package msk_pkg;

  typedef enum logic {
    HUNT    = 1'b0,
    PAYLOAD = 1'b1
  } deframer_state_t;

  localparam logic [31:0] MSK_SYNC_WORD = 32'h1ACFFC1D;

  // Number of set bits in a 32-bit word; used as a Hamming distance.
  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/msk_sync_correlator.sv
// rtl/msk_sync_correlator.sv - sync word correlator with error tolerance (MSK_DEFRAMER_INVERT_DETECT_EN adds inverted compare)
module msk_sync_correlator
  import msk_pkg::*;
#(
  parameter logic [31:0] SYNC_WORD    = MSK_SYNC_WORD,
  parameter int          SYNC_LEN     = 32,
  parameter int          MAX_SYNC_ERR = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic bit_in,
  input  logic bit_valid,
  input  logic enable,
  input  logic clear,
  output logic hit,
  output logic hit_inv
);

  // Only the SYNC_LEN least significant bits take part in the compare.
  localparam logic [31:0] SYNC_MASK = 32'hFFFF_FFFF >> (32 - SYNC_LEN);
  localparam logic [31:0] SYNC_REF  = SYNC_WORD & SYNC_MASK;
  localparam logic [5:0]  FILL_FULL = 6'(SYNC_LEN);
  localparam logic [5:0]  MAX_ERR   = 6'(MAX_SYNC_ERR);

  logic [31:0] shreg_q, shreg_d;
  logic [5:0]  fill_q, fill_d;
  logic [31:0] shifted;
  logic [5:0]  fill_inc;
  logic        full_now;
  logic        unused_oldest;

  // The oldest bit falls off the window before it is ever compared.
  assign unused_oldest = shreg_q[31];

  // Next window value including the current bit, and the saturating fill count.
  always_comb begin
    shifted  = {shreg_q[30:0], bit_in} & SYNC_MASK;
    fill_inc = (fill_q == FILL_FULL) ? fill_q : fill_q + 6'd1;
    full_now = (fill_inc == FILL_FULL);
    shreg_d  = shreg_q;
    fill_d   = fill_q;
    if (clear) begin
      shreg_d = '0;
      fill_d  = '0;
    end else if (bit_valid && enable) begin
      shreg_d = shifted;
      fill_d  = fill_inc;
    end
  end

  // Hits are combinational so the FSM can react on the same strobe.
  always_comb begin
    hit = bit_valid && enable && full_now &&
          (popcount32(shifted ^ SYNC_REF) <= MAX_ERR);
`ifdef MSK_DEFRAMER_INVERT_DETECT_EN
    hit_inv = bit_valid && enable && full_now &&
              (popcount32((~shifted & SYNC_MASK) ^ SYNC_REF) <= MAX_ERR);
`else
    hit_inv = 1'b0;
`endif
  end

  // Window and fill registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shreg_q <= '0;
      fill_q  <= '0;
    end else begin
      shreg_q <= shreg_d;
      fill_q  <= fill_d;
    end
  end

endmodule

// File: rtl/msk_bit_deframer.sv
// rtl/msk_bit_deframer.sv - sync hunt and payload byte assembly for MSK bit stream (MSK_DEFRAMER_INVERT_DETECT_EN enables polarity recovery)
module msk_bit_deframer
  import msk_pkg::*;
#(
  parameter logic [31:0] SYNC_WORD     = MSK_SYNC_WORD,
  parameter int          SYNC_LEN      = 32,
  parameter int          MAX_SYNC_ERR  = 0,
  parameter int          PAYLOAD_BYTES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  output logic        sof,
  output logic        eof,
  output logic        locked,
  output logic [15:0] frame_cnt,
  output logic        sync_inverted
);

  localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_BYTES - 1);

  deframer_state_t state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  asm_q, asm_d;
  logic [7:0]  byte_out_q, byte_out_d;
  logic        byte_valid_q, byte_valid_d;
  logic        sof_q, sof_d;
  logic        eof_q, eof_d;
  logic        locked_q, locked_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
`ifdef MSK_DEFRAMER_INVERT_DETECT_EN
  logic        inv_q, inv_d;
`endif

  logic       hit;
  logic       hit_inv;
  logic       corr_clear;
  logic       payload_bit;
  logic [7:0] asm_shift;

  msk_sync_correlator #(
    .SYNC_WORD    (SYNC_WORD),
    .SYNC_LEN     (SYNC_LEN),
    .MAX_SYNC_ERR (MAX_SYNC_ERR)
  ) u_corr (
    .clk       (clk),
    .reset_n   (reset_n),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .enable    (state_q == HUNT),
    .clear     (corr_clear),
    .hit       (hit),
    .hit_inv   (hit_inv)
  );

  // Next-state logic: hunt for sync, then assemble PAYLOAD_BYTES bytes MSB first.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    byte_idx_d   = byte_idx_q;
    asm_d        = asm_q;
    byte_out_d   = byte_out_q;
    byte_valid_d = 1'b0;
    sof_d        = 1'b0;
    eof_d        = 1'b0;
    locked_d     = locked_q;
    frame_cnt_d  = frame_cnt_q;
    corr_clear   = 1'b0;
`ifdef MSK_DEFRAMER_INVERT_DETECT_EN
    inv_d        = inv_q;
    payload_bit  = bit_in ^ inv_q;
`else
    payload_bit  = bit_in;
`endif
    asm_shift    = {asm_q[6:0], payload_bit};

    case (state_q)
      HUNT: begin
        // A normal hit takes priority over an inverted one.
        if (bit_valid && (hit || hit_inv)) begin
          state_d    = PAYLOAD;
          locked_d   = 1'b1;
          bit_cnt_d  = '0;
          byte_idx_d = '0;
          asm_d      = '0;
`ifdef MSK_DEFRAMER_INVERT_DETECT_EN
          inv_d      = !hit;
`endif
        end
      end
      PAYLOAD: begin
        if (bit_valid) begin
          asm_d     = asm_shift;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_out_d   = asm_shift;
            byte_valid_d = 1'b1;
            sof_d        = (byte_idx_q == 8'd0);
            eof_d        = (byte_idx_q == LAST_IDX);
            byte_idx_d   = byte_idx_q + 8'd1;
            if (byte_idx_q == LAST_IDX) begin
              state_d     = HUNT;
              locked_d    = 1'b0;
              frame_cnt_d = frame_cnt_q + 16'd1;
              corr_clear  = 1'b1;
            end
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= HUNT;
      bit_cnt_q    <= '0;
      byte_idx_q   <= '0;
      asm_q        <= '0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
      locked_q     <= 1'b0;
      frame_cnt_q  <= '0;
`ifdef MSK_DEFRAMER_INVERT_DETECT_EN
      inv_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_idx_q   <= byte_idx_d;
      asm_q        <= asm_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      sof_q        <= sof_d;
      eof_q        <= eof_d;
      locked_q     <= locked_d;
      frame_cnt_q  <= frame_cnt_d;
`ifdef MSK_DEFRAMER_INVERT_DETECT_EN
      inv_q        <= inv_d;
`endif
    end
  end

  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;
  assign sof        = sof_q;
  assign eof        = eof_q;
  assign locked     = locked_q;
  assign frame_cnt  = frame_cnt_q;
`ifdef MSK_DEFRAMER_INVERT_DETECT_EN
  assign sync_inverted = inv_q;
`else
  assign sync_inverted = 1'b0;
`endif

endmodule

// File: tb/tb_msk_bit_deframer.sv
// tb/tb_msk_bit_deframer.sv - self-checking bench for msk_bit_deframer
module tb_msk_bit_deframer;

  localparam logic [31:0] SW     = 32'h1ACFFC1D;
  localparam int          SL     = 32;
  localparam bit          INV_EN = 1'b0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, bit_in, bit_valid;
  logic [7:0]  byte_out0, byte_out1;
  logic        bv0, bv1, sof0, sof1, eof0, eof1, lk0, lk1, si0, si1;
  logic [15:0] fc0, fc1;

  msk_bit_deframer dut0 (
    .clk(clk), .reset_n(reset_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .byte_out(byte_out0), .byte_valid(bv0), .sof(sof0), .eof(eof0),
    .locked(lk0), .frame_cnt(fc0), .sync_inverted(si0)
  );

  msk_bit_deframer #(.MAX_SYNC_ERR(1), .PAYLOAD_BYTES(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .byte_out(byte_out1), .byte_valid(bv1), .sof(sof1), .eof(eof1),
    .locked(lk1), .frame_cnt(fc1), .sync_inverted(si1)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Behavioural model: bit history per instance, sync judged on the last SL bits.
  int me [2] = '{0, 1};
  int pb [2] = '{16, 1};
  bit hist [2][4096];
  int hn [2];
  bit pay [2];
  int pv [2], pn [2], nb [2], fcm [2], e_byte [2];
  bit e_bv [2], e_sof [2], e_eof [2], e_lk [2], e_inv [2];
  logic [31:0] sw_v = SW;

  task automatic model_step(input int i);
    int errs, errs_i;
    bit b;
    e_bv[i] = 0; e_sof[i] = 0; e_eof[i] = 0;
    if (!reset_n) begin
      hn[i] = 0; pay[i] = 0; fcm[i] = 0; e_byte[i] = 0; e_lk[i] = 0; e_inv[i] = 0; pn[i] = 0;
    end else if (bit_valid) begin
      if (!pay[i]) begin
        if (hn[i] < 4096) begin
          hist[i][hn[i]] = bit_in;
          hn[i]++;
        end
        if (hn[i] >= SL) begin
          errs = 0; errs_i = 0;
          for (int k = 0; k < SL; k++) begin
            b = hist[i][hn[i] - SL + k];
            if (b != sw_v[SL - 1 - k]) errs++;
            else errs_i++;
          end
          if (errs <= me[i]) begin
            pay[i] = 1; e_inv[i] = 0;
          end else if (INV_EN && errs_i <= me[i]) begin
            pay[i] = 1; e_inv[i] = 1;
          end
          if (pay[i]) begin
            e_lk[i] = 1; pn[i] = 0; nb[i] = 0; pv[i] = 0;
          end
        end
      end else begin
        b = bit_in ^ e_inv[i];
        pv[i] = ((pv[i] << 1) | int'(b)) & 255;
        pn[i]++;
        if (pn[i] == 8) begin
          e_byte[i] = pv[i]; e_bv[i] = 1;
          e_sof[i] = (nb[i] == 0);
          e_eof[i] = (nb[i] == pb[i] - 1);
          nb[i]++; pn[i] = 0;
          if (nb[i] == pb[i]) begin
            pay[i] = 0; e_lk[i] = 0; fcm[i] = (fcm[i] + 1) % 65536; hn[i] = 0;
          end
        end
      end
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
  end

  function automatic logic [31:0] exp_pack(input int i);
    logic [7:0]  eb;
    logic [15:0] ef;
    eb = e_byte[i][7:0];
    ef = fcm[i][15:0];
    return 32'({e_bv[i], e_sof[i], e_eof[i], e_lk[i], e_inv[i], eb, ef});
  endfunction

  logic [31:0] act0, act1;
  assign act0 = 32'({bv0, sof0, eof0, lk0, si0, byte_out0, fc0});
  assign act1 = 32'({bv1, sof1, eof1, lk1, si1, byte_out1, fc1});

  int log0[$];
  int log1[$];

  // Per-cycle compare against the model, plus a log of received bytes.
  always @(negedge clk) begin
    check("cyc_dut0", act0, exp_pack(0));
    check("cyc_dut1", act1, exp_pack(1));
    if (bv0) log0.push_back(int'({sof0, eof0, byte_out0}));
    if (bv1) log1.push_back(int'({sof1, eof1, byte_out1}));
  end

  function automatic int log_at0(input int idx);
    if (idx >= 0 && idx < log0.size()) return log0[idx];
    return -1;
  endfunction

  function automatic int log_at1(input int idx);
    if (idx >= 0 && idx < log1.size()) return log1[idx];
    return -1;
  endfunction

  task automatic send_bit(input logic b, input int gap);
    bit_in = b;
    bit_valid = 1'b1;
    @(negedge clk);
    bit_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] v, input int gap);
    for (int j = 7; j >= 0; j--) send_bit(v[j], gap);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int j = 31; j >= 0; j--) send_bit(w[j], gap);
  endtask

  int b0, b1;
  logic [7:0] t;

  initial begin
    reset_n = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dut0", act0, 32'h0);
    check("rst_dut1", act1, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Random preamble, sync, 16 bytes 0x00..0x0F at 20-clk spacing.
    b0 = log0.size(); b1 = log1.size();
    for (int k = 0; k < 32; k++) send_bit(1'($urandom_range(0, 1)), 19);
    send_word(SW, 19);
    for (int k = 0; k < 16; k++) send_byte(8'(k), 19);
    repeat (5) @(negedge clk);
    check("t1_count", 32'(log0.size() - b0), 32'd16);
    for (int k = 0; k < 16; k++)
      check($sformatf("t1_byte%0d", k), 32'(log_at0(b0 + k)), 32'({k == 0, k == 15, 8'(k)}));
    check("t1_fc", 32'(fc0), 32'd1);
    check("t1_dut1_first", 32'(log_at1(b1)), 32'h300);

    // Sync with one flipped bit: only the tolerant instance locks.
    b0 = log0.size(); b1 = log1.size();
    send_word(SW ^ 32'h0000_0100, 3);
    for (int k = 0; k < 16; k++) send_byte(8'(8'h30 + k), 3);
    repeat (5) @(negedge clk);
    check("t2_dut0_none", 32'(log0.size() - b0), 32'd0);
    check("t2_fc0", 32'(fc0), 32'd1);
    check("t2_dut1_count", 32'(log1.size() - b1), 32'd1);
    check("t2_dut1_byte", 32'(log_at1(b1)), 32'h330);
    check("t2_fc1", 32'(fc1), 32'd2);

    // Back-to-back frames of 0xAA with bit_valid held high.
    b0 = log0.size(); b1 = log1.size();
    send_word(SW, 0);
    for (int k = 0; k < 16; k++) send_byte(8'hAA, 0);
    send_word(SW, 0);
    for (int k = 0; k < 16; k++) send_byte(8'hAA, 0);
    repeat (5) @(negedge clk);
    check("t3_count0", 32'(log0.size() - b0), 32'd32);
    for (int k = 0; k < 32; k++)
      check($sformatf("t3_byte%0d", k), 32'(log_at0(b0 + k)),
            32'({(k % 16) == 0, (k % 16) == 15, 8'hAA}));
    check("t3_fc0", 32'(fc0), 32'd3);
    check("t3_count1", 32'(log1.size() - b1), 32'd2);
    check("t3_fc1", 32'(fc1), 32'd4);

    // Reset after byte 5 of a frame, then a clean frame.
    b0 = log0.size();
    send_word(SW, 3);
    for (int k = 0; k < 5; k++) send_byte(8'(8'h40 + k), 3);
    check("t4_partial", 32'(log0.size() - b0), 32'd5);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("t4_rst0", act0, 32'h0);
    check("t4_rst1", act1, 32'h0);
    b0 = log0.size();
    send_word(SW, 3);
    for (int k = 0; k < 16; k++) send_byte(8'(8'h50 + k), 3);
    repeat (5) @(negedge clk);
    check("t4_count0", 32'(log0.size() - b0), 32'd16);
    for (int k = 0; k < 16; k++)
      check($sformatf("t4_byte%0d", k), 32'(log_at0(b0 + k)),
            32'({k == 0, k == 15, 8'(8'h50 + k)}));
    check("t4_fc0", 32'(fc0), 32'd1);
    check("t4_fc1", 32'(fc1), 32'd1);

    // Inverted sync and payload: no lock in the default build.
    b0 = log0.size(); b1 = log1.size();
    send_word(~SW, 3);
    for (int k = 0; k < 16; k++) begin
      t = 8'(8'h11 * k);
      send_byte(~t, 3);
    end
    repeat (5) @(negedge clk);
    check("t5_none0", 32'(log0.size() - b0), 32'd0);
    check("t5_none1", 32'(log1.size() - b1), 32'd0);
    check("t5_inv0", 32'(si0), 32'd0);
    check("t5_lock0", 32'(lk0), 32'd0);

    // Single-byte frame on the PAYLOAD_BYTES=1 instance.
    b0 = log0.size(); b1 = log1.size();
    send_word(SW, 5);
    send_byte(8'h5A, 5);
    repeat (5) @(negedge clk);
    check("t6_count1", 32'(log1.size() - b1), 32'd1);
    check("t6_byte1", 32'(log_at1(b1)), 32'h35A);
    check("t6_lock1", 32'(lk1), 32'd0);
    check("t6_fc1", 32'(fc1), 32'd2);
    check("t6_lock0", 32'(lk0), 32'd1);
    check("t6_byte0", 32'(log_at0(b0)), 32'h25A);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
